// File: rtl/router_pkg.sv
// router_pkg: shared sizing and header-field positions for the router FIFO.
package router_pkg;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int HDR_FLAG_BIT = WIDTH;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-port packet FIFO with header flag and read-side byte counter.
module router_fifo #(
  parameter int DEPTH = router_pkg::DEPTH,
  parameter int WIDTH = router_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_active
);
  import router_pkg::*;
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH:0] mem_q [DEPTH];
  logic [WIDTH:0] rd_entry;
  logic wr_acc, rd_acc;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_acc = write_enb && !full;
  assign rd_acc = read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign data_out = dout_q;
  assign pkt_active = cnt_q != 7'd0;
  always_comb begin
    wr_ptr_d = soft_rst ? '0 : wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d = soft_rst ? '0 : rd_ptr_q + (AW+1)'(rd_acc);
    dout_d = soft_rst ? '0 : rd_acc ? rd_entry[WIDTH-1:0] : dout_q;
    // a header loads its payload length plus the trailing parity byte
    cnt_d = soft_rst ? '0
          : !rd_acc ? cnt_q
          : rd_entry[HDR_FLAG_BIT] ? 7'(rd_entry[LEN_MSB:LEN_LSB]) + 7'd1
          : cnt_q - 7'(cnt_q != 7'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst && !soft_rst && wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed self-checking bench for router_fifo.
module tb_router_fifo;
  logic clk = 1'b0;
  logic rst, soft_rst, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic full, empty, pkt_active;
  int n_cmp = 0;
  int n_err = 0;
  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .pkt_active(pkt_active)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic s, input logic we, input logic re,
                      input logic lfd, input logic [7:0] d);
    rst = r; soft_rst = s; write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
    @(posedge clk);
    #1;
    rst = 0; soft_rst = 0; write_enb = 0; read_enb = 0; lfd_state = 0; data_in = 8'h00;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] pkt [5];
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h2F;
    step(1, 0, 0, 0, 0, 8'h00);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_pkt", 32'(pkt_active), 0);
    chk("rst_dout", 32'(data_out), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, i == 0, pkt[i]);
    chk("pkt_empty", 32'(empty), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 8'h00);
      chk($sformatf("pkt_rd%0d", i), 32'(data_out), 32'(pkt[i]));
      chk($sformatf("pkt_act%0d", i), 32'(pkt_active), i < 4 ? 1 : 0);
    end
    chk("pkt_done_empty", 32'(empty), 1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        step(0, 0, 1, 0, 0, 8'(i * 7 + r));
        chk($sformatf("fill%0d_full%0d", r, i), 32'(full), i == 15 ? 1 : 0);
      end
      step(0, 0, 1, 0, 0, 8'hFF);
      chk($sformatf("fill%0d_17th_full", r), 32'(full), 1);
      for (int i = 0; i < 16; i++) begin
        step(0, 0, 0, 1, 0, 8'h00);
        chk($sformatf("drain%0d_%0d", r, i), 32'(data_out), 32'(8'(i * 7 + r)));
      end
      chk($sformatf("drain%0d_empty", r), 32'(empty), 1);
      chk($sformatf("drain%0d_pkt", r), 32'(pkt_active), 0);
    end
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 8'(8'h40 + i));
    chk("full_rw_pre", 32'(full), 1);
    step(0, 0, 1, 1, 0, 8'hEE);
    chk("full_rw_dout", 32'(data_out), 32'h40);
    chk("full_rw_full", 32'(full), 0);
    for (int i = 1; i < 16; i++) begin
      step(0, 0, 0, 1, 0, 8'h00);
      chk($sformatf("full_rw_rd%0d", i), 32'(data_out), 32'(8'h40 + i));
    end
    chk("full_rw_empty", 32'(empty), 1);
    step(0, 0, 1, 1, 0, 8'hA5);
    chk("empty_rw_empty", 32'(empty), 0);
    chk("empty_rw_hold", 32'(data_out), 32'h4F);
    step(0, 0, 0, 1, 0, 8'h00);
    chk("empty_rw_rd", 32'(data_out), 32'hA5);
    chk("empty_rw_empty2", 32'(empty), 1);
    step(0, 0, 1, 0, 1, 8'h0D);
    for (int i = 1; i < 6; i++) step(0, 0, 1, 0, 0, 8'(i));
    step(0, 0, 0, 1, 0, 8'h00);
    chk("srst_pre_pkt", 32'(pkt_active), 1);
    chk("srst_pre_dout", 32'(data_out), 32'h0D);
    step(0, 1, 1, 1, 0, 8'h77);
    chk("srst_empty", 32'(empty), 1);
    chk("srst_dout", 32'(data_out), 0);
    chk("srst_pkt", 32'(pkt_active), 0);
    step(0, 0, 1, 0, 0, 8'h5A);
    step(0, 0, 0, 1, 0, 8'h00);
    chk("srst_after_rd", 32'(data_out), 32'h5A);
    chk("srst_after_empty", 32'(empty), 1);
    step(0, 0, 1, 0, 1, 8'h0D);
    step(0, 0, 1, 0, 0, 8'h11);
    step(0, 0, 0, 1, 0, 8'h00);
    chk("rst_mid_pre_pkt", 32'(pkt_active), 1);
    step(1, 1, 1, 1, 0, 8'h99);
    chk("rst_mid_empty", 32'(empty), 1);
    chk("rst_mid_full", 32'(full), 0);
    chk("rst_mid_pkt", 32'(pkt_active), 0);
    chk("rst_mid_dout", 32'(data_out), 0);
    step(0, 0, 0, 1, 0, 8'h00);
    chk("rst_mid_noread", 32'(data_out), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of storage entries (power of two).
REQ-002 Parameter: WIDTH, 8, payload byte width; each entry is WIDTH+1 bits (byte plus header flag).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 soft_rst  input  1  per-port flush from router control (timeout), synchronous, active-high.
REQ-006 write_enb  input  1  write request for data_in this cycle.
REQ-007 read_enb  input  1  read request from destination this cycle.
REQ-008 lfd_state  input  1  marks the byte being written as a packet header.
REQ-009 data_in  input  WIDTH  byte from the register stage.
REQ-010 data_out  output  WIDTH  registered read byte.
REQ-011 full  output  1  no free entry.
REQ-012 empty  output  1  no stored entry.
REQ-013 pkt_active  output  1  read-side byte counter nonzero (packet in progress at the reader).

Function
REQ-014 Write accepted iff write_enb && !full; stores {lfd_state, data_in} at wr_ptr and increments wr_ptr.
REQ-015 Read accepted iff read_enb && !empty; data_out <= stored byte at rd_ptr the next edge (1-cycle latency); rd_ptr increments.
REQ-016 Pointers are log2(DEPTH)+1 bits; index wraps modulo DEPTH, extra MSB tracks lap.
REQ-017 empty = (wr_ptr == rd_ptr); full = index equal and MSB different; both combinational from registered pointers.
REQ-018 Simultaneous read and write when full: read accepted, write rejected (full evaluated before the edge); data lost is the writer's responsibility.
REQ-019 Simultaneous read and write when empty: write accepted, read ignored; data_out holds.
REQ-020 Simultaneous read and write otherwise: both accepted, occupancy unchanged.
REQ-021 When no read is accepted, data_out holds its previous value.
REQ-022 Byte counter, 7 bits: on accepted read of a header-flagged entry, count <= header[7:2] + 1 (payload plus parity byte).
REQ-023 On accepted read of a non-header entry with count > 0, count decrements by 1; at count 0 it stays 0.
REQ-024 pkt_active = (count != 0).
REQ-025 soft_rst (when rst low): pointers, counter and data_out cleared to 0 next edge; writes/reads in that cycle ignored; memory contents not cleared.
REQ-026 Priority: rst > soft_rst > read/write.

Reset
REQ-027 On rst: wr_ptr=0, rd_ptr=0, count=0, data_out=0x00; hence empty=1, full=0, pkt_active=0 after the edge.
REQ-028 Reset mid-packet discards all stored entries; memory array need not be reset.

Structure
REQ-029 Shared package router_pkg holds DEPTH, WIDTH, ADDR_W = log2(DEPTH), HDR_FLAG_BIT = WIDTH, LEN_MSB/LEN_LSB = 7/2.
REQ-030 Single flat module; storage as an inferred register array, no sub-module.

Verification
REQ-031 Reset, then write header 0x0D (lfd=1) plus bytes 0x11,0x22,0x33,parity 0x2F -> empty=0; five reads return 0x0D,0x11,0x22,0x33,0x2F, pkt_active high from read of 0x0D until after 0x2F, then empty=1.
REQ-032 Write 16 bytes with read_enb=0 -> full=1 after 16th; 17th write ignored; 16 reads return bytes in order, wrap verified by repeating twice.
REQ-033 Full FIFO, write_enb=1 and read_enb=1 same cycle -> occupancy 15, full=0, written byte absent.
REQ-034 Empty FIFO, write 0xA5 and read same cycle -> empty=0 next cycle, data_out unchanged; next read gives 0xA5.
REQ-035 Load 6 bytes, assert soft_rst one cycle -> empty=1, data_out=0x00, pkt_active=0; subsequent write/read of 0x5A returns 0x5A.
REQ-036 rst asserted mid-packet with soft_rst and write_enb also high -> all state matches REQ-027 next edge.
